rca_multiword_seq: RTL

Multi-precision add sequencer. It adds two WORDS*WIDTH-bit operands by time-multiplexing a single WIDTH-bit ripple carry adder (rca), one word slice per clock, least significant word first. The inter-word carry is held in a register. Valid/ready handshakes on both input and output let it sit between operand producers and result consumers that run wider than the adder.

---
 rtl/rca_seq_pkg.sv | 21 ++
 rtl/rca.sv | 24 ++
 rtl/rca_multiword_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/rca_seq_pkg.sv
// Shared definitions for the multi-word add sequencer: FSM state encoding and
// the word-index width helper.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to index n word slices; never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rca.sv
// WIDTH-bit ripple carry adder, purely combinational: sum_o/carry_o = a_i + b_i + carry_i.
module rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Full-adder chain, carry rippling from bit 0 upwards.
  always_comb begin
    logic c;
    c     = carry_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    carry_o = c;
  end

endmodule

// File: rtl/rca_multiword_seq.sv
// Multi-precision adder: one shared WIDTH-bit rca processes WORDS slices, LS word
// first, with the inter-word carry held in a register and valid/ready on both sides.
module rca_multiword_seq
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   carry_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   carry_out
);

  localparam int TOTAL = WIDTH * WORDS;
  localparam int IDXW  = idx_width(WORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [IDXW-1:0]  idx_d;
  logic [TOTAL-1:0] a_q;
  logic [TOTAL-1:0] b_q;
  logic [TOTAL-1:0] sum_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             carry_out_q;

  logic [WIDTH-1:0] a_word_s;
  logic [WIDTH-1:0] b_word_s;
  logic [WIDTH-1:0] rca_sum_s;
  logic             rca_carry_s;
  logic             last_word_s;

  assign a_word_s    = a_q[int'(idx_q)*WIDTH +: WIDTH];
  assign b_word_s    = b_q[int'(idx_q)*WIDTH +: WIDTH];
  assign idx_d       = idx_q + IDXW'(1);
  assign last_word_s = (idx_q == LAST_IDX);

  rca #(.WIDTH(WIDTH)) u_rca (
    .a_i     (a_word_s),
    .b_i     (b_word_s),
    .carry_i (carry_q),
    .sum_o   (rca_sum_s),
    .carry_o (rca_carry_s)
  );

  // Sequencer FSM; handshake outputs are registered and updated with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= carry_in;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[int'(idx_q)*WIDTH +: WIDTH] <= rca_sum_s;
          carry_q <= rca_carry_s;
          idx_q   <= idx_d;
          if (last_word_s) begin
            carry_out_q <= rca_carry_s;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Result holds until the consumer takes it; new operands wait for IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule
